// File: rtl/dac_run_sequencer.sv
// dac_run_sequencer: sequences one DAC/ADC acquisition run per GPIO trigger edge.
// Phases IDLE -> PRE -> RUN -> POST -> IDLE; empty phases are skipped.
// Optional feature macro: LOCKING_WAVEFORM_EN (lock_active high in IDLE after a completed run).
module dac_run_sequencer #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             trigger_in,
    input  logic             abort,
    input  logic [CNT_W-1:0] pre_delay,
    input  logic [CNT_W-1:0] run_cycles,
    input  logic [CNT_W-1:0] post_delay,
    input  logic             mask_en,
    output logic             busy,
    output logic             fifo_rd_en,
    output logic             mask_active,
    output logic             adc_trig,
    output logic             done,
    output logic             overrun,
    output logic             lock_active
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        RUN  = 2'd2,
        POST = 2'd3
    } state_t;

    state_t                 state_q;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_nxt;
    logic [CNT_W-1:0]       run_sh;
    logic [CNT_W-1:0]       post_sh;
    logic                   mask_sh;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev;
    logic                   trig_pulse;
    logic                   start;
    logic                   done_nxt;
    logic                   mask_nxt;
    logic [CNT_W-1:0]       run_sel;
    logic [CNT_W-1:0]       post_sel;

    // Trigger synchronizer plus registered rising-edge detect.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q     <= '0;
            sync_prev  <= 1'b0;
            trig_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], trigger_in};
            sync_prev  <= sync_q[SYNC_STAGES-1];
            trig_pulse <= sync_q[SYNC_STAGES-1] & ~sync_prev;
        end
    end

    // Next-state and counter logic; the trigger cycle uses live config, later phases the shadows.
    always_comb begin
        start     = (state_q == IDLE) && trig_pulse && !abort;
        run_sel   = start ? run_cycles : run_sh;
        post_sel  = start ? post_delay : post_sh;
        mask_nxt  = start ? mask_en    : mask_sh;
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        done_nxt  = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trig_pulse) begin
                        if (pre_delay != '0) begin
                            state_nxt = PRE;
                            cnt_nxt   = pre_delay - CNT_W'(1);
                        end else if (run_sel != '0) begin
                            state_nxt = RUN;
                            cnt_nxt   = run_sel - CNT_W'(1);
                        end else if (post_sel != '0) begin
                            state_nxt = POST;
                            cnt_nxt   = post_sel - CNT_W'(1);
                        end else begin
                            done_nxt = 1'b1;
                        end
                    end
                end
                PRE: begin
                    if (cnt_q != '0) begin
                        cnt_nxt = cnt_q - CNT_W'(1);
                    end else if (run_sel != '0) begin
                        state_nxt = RUN;
                        cnt_nxt   = run_sel - CNT_W'(1);
                    end else if (post_sel != '0) begin
                        state_nxt = POST;
                        cnt_nxt   = post_sel - CNT_W'(1);
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                RUN: begin
                    if (cnt_q != '0) begin
                        cnt_nxt = cnt_q - CNT_W'(1);
                    end else if (post_sel != '0) begin
                        state_nxt = POST;
                        cnt_nxt   = post_sel - CNT_W'(1);
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                POST: begin
                    if (cnt_q != '0) begin
                        cnt_nxt = cnt_q - CNT_W'(1);
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State, shadow config and registered outputs decoded from the next state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            run_sh      <= '0;
            post_sh     <= '0;
            mask_sh     <= 1'b0;
            busy        <= 1'b0;
            fifo_rd_en  <= 1'b0;
            mask_active <= 1'b0;
            adc_trig    <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            if (start) begin
                run_sh  <= run_cycles;
                post_sh <= post_delay;
                mask_sh <= mask_en;
            end
            busy        <= (state_nxt != IDLE);
            fifo_rd_en  <= (state_nxt == RUN);
            mask_active <= (state_nxt == RUN) && mask_nxt;
            adc_trig    <= (state_nxt == RUN) && (state_q != RUN);
            done        <= done_nxt;
            if (trig_pulse && (state_q != IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef LOCKING_WAVEFORM_EN
    logic locked_q;
    logic locked_nxt;

    // Lock is armed by a completed run and dropped by abort.
    always_comb begin
        locked_nxt = locked_q;
        if (abort) begin
            locked_nxt = 1'b0;
        end else if (done_nxt) begin
            locked_nxt = 1'b1;
        end
    end

    // Locking waveform plays only while idle between runs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            locked_q    <= 1'b0;
            lock_active <= 1'b0;
        end else begin
            locked_q    <= locked_nxt;
            lock_active <= locked_nxt && (state_nxt == IDLE);
        end
    end
`else
    assign lock_active = 1'b0;
`endif

endmodule
